// File: rtl/gcd_div_check.sv
// Divisibility checker for GCD results: confirms G divides both A and B by
// repeated subtraction, reporting pass/fail, a G==0 flag and both remainders.
module gcd_div_check #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] g_in,
    output logic             done,
    output logic             pass,
    output logic             g_zero,
    output logic [WIDTH-1:0] rem_a,
    output logic [WIDTH-1:0] rem_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOD_A = 2'd1,
        MOD_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rg;

    logic             accept;
    logic             a_ge;
    logic             b_ge;
    logic             load_result;
    logic [WIDTH-1:0] res_a;
    logic [WIDTH-1:0] res_b;
    logic             res_g_zero;

    assign accept = in_valid && (state == IDLE);
    assign a_ge   = (ra >= rg);
    assign b_ge   = (rb >= rg);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (g_in == '0) ? DONE : MOD_A;
                end
            end
            MOD_A: begin
                if (!a_ge) begin
                    state_next = MOD_B;
                end
            end
            MOD_B: begin
                if (!b_ge) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    done     = 1'b1;
            default: ;
        endcase
    end

    // Working registers: latched on accept, then reduced modulo rg in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra <= '0;
            rb <= '0;
            rg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ra <= a_in;
                        rb <= b_in;
                        rg <= g_in;
                    end
                end
                MOD_A: begin
                    if (a_ge) begin
                        ra <= ra - rg;
                    end
                end
                MOD_B: begin
                    if (b_ge) begin
                        rb <= rb - rg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Results are captured on the edge entering DONE so they are already
    // valid while done is high; G==0 short-circuits straight from IDLE.
    always_comb begin
        load_result = 1'b0;
        res_a       = ra;
        res_b       = rb;
        res_g_zero  = 1'b0;
        if (accept && (g_in == '0)) begin
            load_result = 1'b1;
            res_a       = a_in;
            res_b       = b_in;
            res_g_zero  = 1'b1;
        end else if ((state == MOD_B) && !b_ge) begin
            load_result = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_a  <= '0;
            rem_b  <= '0;
            pass   <= 1'b0;
            g_zero <= 1'b0;
        end else if (load_result) begin
            rem_a  <= res_a;
            rem_b  <= res_b;
            pass   <= (res_a == '0) && (res_b == '0);
            g_zero <= res_g_zero;
        end
    end

endmodule

// File: tb/tb_gcd_div_check.sv
// Directed self-checking bench for gcd_div_check with hand-computed results.
module tb_gcd_div_check;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] g_in;
    logic             done;
    logic             pass;
    logic             g_zero;
    logic [WIDTH-1:0] rem_a;
    logic [WIDTH-1:0] rem_b;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int done_count = 0;

    gcd_div_check #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .g_in     (g_in),
        .done     (done),
        .pass     (pass),
        .g_zero   (g_zero),
        .rem_a    (rem_a),
        .rem_b    (rem_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) accepts++;
        if (done) done_count++;
    end

    // Presents a triple in IDLE and returns #1 after the accepting edge.
    task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] g);
        a_in     = a;
        b_in     = b;
        g_in     = g;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen; -1 on timeout.
    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (!done && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        g_in     = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || g_zero !== 1'b0 ||
            rem_a !== 8'd0 || rem_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b done=%b pass=%b gz=%b ra=%0d rb=%0d, want 1 0 0 0 0 0",
                     in_ready, done, pass, g_zero, rem_a, rem_b);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int lat;
        start(8'd48, 8'd18, 8'd6);
        wait_done(100, lat);
        checks++;
        if (lat !== 13 || pass !== 1'b1 || rem_a !== 8'd0 || rem_b !== 8'd0 || g_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_48_18_6: lat=%0d pass=%b ra=%0d rb=%0d gz=%b, want 13 1 0 0 0",
                     lat, pass, rem_a, rem_b, g_zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b ready=%b, want 0 1", done, in_ready);
        end
        start(8'd48, 8'd18, 8'd5);
        wait_done(100, lat);
        checks++;
        if (lat !== 14 || pass !== 1'b0 || rem_a !== 8'd3 || rem_b !== 8'd3 || g_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_48_18_5: lat=%0d pass=%b ra=%0d rb=%0d gz=%b, want 14 0 3 3 0",
                     lat, pass, rem_a, rem_b, g_zero);
        end
        @(posedge clk);
        #1;
    endtask

    // G==0 skips the reduction: done is already high in the cycle after accept.
    task automatic test_g_zero;
        int lat;
        start(8'd0, 8'd0, 8'd0);
        wait_done(10, lat);
        checks++;
        if (lat !== 0 || pass !== 1'b1 || g_zero !== 1'b1 || rem_a !== 8'd0 || rem_b !== 8'd0) begin
            errors++;
            $display("FAIL gzero_0_0: lat=%0d pass=%b gz=%b ra=%0d rb=%0d, want 0 1 1 0 0",
                     lat, pass, g_zero, rem_a, rem_b);
        end
        @(posedge clk);
        #1;
        start(8'd7, 8'd0, 8'd0);
        wait_done(10, lat);
        checks++;
        if (lat !== 0 || pass !== 1'b0 || g_zero !== 1'b1 || rem_a !== 8'd7 || rem_b !== 8'd0) begin
            errors++;
            $display("FAIL gzero_7_0: lat=%0d pass=%b gz=%b ra=%0d rb=%0d, want 0 0 1 7 0",
                     lat, pass, g_zero, rem_a, rem_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_boundary;
        int lat;
        // A==0 and G>B: both phases last one cycle, no subtraction.
        start(8'd0, 8'd5, 8'd7);
        wait_done(100, lat);
        checks++;
        if (lat !== 2 || pass !== 1'b0 || rem_a !== 8'd0 || rem_b !== 8'd5 || g_zero !== 1'b0) begin
            errors++;
            $display("FAIL bound_0_5_7: lat=%0d pass=%b ra=%0d rb=%0d gz=%b, want 2 0 0 5 0",
                     lat, pass, rem_a, rem_b, g_zero);
        end
        @(posedge clk);
        #1;
        // G==A==B: exactly one subtraction per phase.
        start(8'd7, 8'd7, 8'd7);
        wait_done(100, lat);
        checks++;
        if (lat !== 4 || pass !== 1'b1 || rem_a !== 8'd0 || rem_b !== 8'd0) begin
            errors++;
            $display("FAIL bound_7_7_7: lat=%0d pass=%b ra=%0d rb=%0d, want 4 1 0 0",
                     lat, pass, rem_a, rem_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_worst_case;
        int lat;
        int ready_seen;
        int acc0;
        start(8'd255, 8'd255, 8'd1);
        acc0       = accepts;
        lat        = 0;
        ready_seen = 0;
        while (!done && lat < 600) begin
            if (lat == 100) begin
                a_in     = 8'd3;
                b_in     = 8'd3;
                g_in     = 8'd3;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (in_ready) ready_seen++;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat !== 512 || pass !== 1'b1 || rem_a !== 8'd0 || rem_b !== 8'd0) begin
            errors++;
            $display("FAIL worst_case: lat=%0d pass=%b ra=%0d rb=%0d, want 512 1 0 0",
                     lat, pass, rem_a, rem_b);
        end
        checks++;
        if (ready_seen !== 0 || accepts !== acc0) begin
            errors++;
            $display("FAIL busy_ignore: ready_cycles=%0d extra_accepts=%0d, want 0 0",
                     ready_seen, accepts - acc0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort;
        int lat;
        int d0;
        start(8'd200, 8'd100, 8'd10);
        repeat (5) @(posedge clk);
        #1;
        d0  = done_count;
        rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || g_zero !== 1'b0 || rem_a !== 8'd0 ||
            rem_b !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset: done=%b pass=%b gz=%b ra=%0d rb=%0d ready=%b, want 0 0 0 0 0 1",
                     done, pass, g_zero, rem_a, rem_b, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_count !== d0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_done: pulses=%0d ready=%b, want 0 1", done_count - d0, in_ready);
        end
        start(8'd9, 8'd6, 8'd3);
        wait_done(100, lat);
        checks++;
        if (lat !== 7 || pass !== 1'b1 || rem_a !== 8'd0 || rem_b !== 8'd0) begin
            errors++;
            $display("FAIL after_abort_9_6_3: lat=%0d pass=%b ra=%0d rb=%0d, want 7 1 0 0",
                     lat, pass, rem_a, rem_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        int acc0;
        acc0     = accepts;
        a_in     = 8'd12;
        b_in     = 8'd8;
        g_in     = 8'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in = 8'd10;
        b_in = 8'd4;
        g_in = 8'd3;
        wait_done(100, lat);
        checks++;
        if (lat !== 7 || pass !== 1'b1 || rem_a !== 8'd0 || rem_b !== 8'd0) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d pass=%b ra=%0d rb=%0d, want 7 1 0 0",
                     lat, pass, rem_a, rem_b);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1 || pass !== 1'b1 || rem_a !== 8'd0 || rem_b !== 8'd0) begin
            errors++;
            $display("FAIL b2b_gap_hold: done=%b ready=%b pass=%b ra=%0d rb=%0d, want 0 1 1 0 0",
                     done, in_ready, pass, rem_a, rem_b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(100, lat);
        checks++;
        if (lat !== 6 || pass !== 1'b0 || rem_a !== 8'd1 || rem_b !== 8'd1) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d pass=%b ra=%0d rb=%0d, want 6 0 1 1",
                     lat, pass, rem_a, rem_b);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || accepts - acc0 !== 2) begin
            errors++;
            $display("FAIL b2b_accepts: ready=%b done=%b accepts=%0d, want 1 0 2",
                     in_ready, done, accepts - acc0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_g_zero();
        test_boundary();
        test_worst_case();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
